// File: rtl/seq_alu.sv
// Multi-cycle ALU with a start/done handshake. Single-cycle ops complete on the start edge.
// MULH/MULL run a WIDTH-step shift-add multiplier, then a sign-fix cycle.
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OP_W-1:0]  alu_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               sign;
  logic               op_hi;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_err;
  logic               is_mul;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mul_res;
  logic               last_step;

  assign is_mul    = alu_op[0] & ~alu_op[2];
  assign last_step = (cnt == CW'(WIDTH - 1));

  // Magnitudes read as unsigned: |-2^(W-1)| = 2^(W-1) still fits in W unsigned bits.
  assign a_mag = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign b_mag = B[WIDTH-1] ? (~B + 1'b1) : B;

  assign prod    = sign ? (~acc + 1'b1) : acc;
  assign mul_res = op_hi ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
  assign busy    = (state != IDLE);

  // NOTE: every output of an always_comb gets a default first; a missing branch would infer a latch.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (alu_op[2:0])
      3'b000:  alu_res = A + B;
      3'b010:  alu_res = A - B;
      3'b100:  alu_res = A & B;
      3'b101:  alu_res = A | B;
      3'b110:  alu_res = A ^ B;
      3'b111:  alu_err = 1'b1;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && is_mul) state_nxt = MUL;
      MUL:     if (last_step) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: the multiplier registers are reset too, so an aborted multiply leaves no stale product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      sign   <= 1'b0;
      op_hi  <= 1'b0;
      result <= '0;
      z      <= 1'b0;
      err    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul) begin
              mcand  <= {{WIDTH{1'b0}}, a_mag};
              mplier <= b_mag;
              sign   <= A[WIDTH-1] ^ B[WIDTH-1];
              op_hi  <= ~alu_op[1];
              acc    <= '0;
              cnt    <= '0;
            end else begin
              result <= alu_res;
              z      <= (alu_res == '0);
              err    <= alu_err;
              done   <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        FIX: begin
          result <= mul_res;
          z      <= (mul_res == '0);
          err    <= 1'b0;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=8) with hand-computed expected values.
module tb_seq_alu;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_MULH = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MULL = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic [2:0] alu_op = '0;
  logic       busy, done, z, err;
  logic [7:0] result;

  int total = 0;
  int bad   = 0;

  seq_alu #(.WIDTH(8), .OP_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .alu_op(alu_op),
    .busy(busy), .done(done), .result(result), .z(z), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op, wait (bounded) for done, then check latency, busy cycles, outputs and pulse width.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_res, input logic exp_z, input logic exp_err);
    int n = 0;
    int busy_seen = 0;
    int exp_lat;
    exp_lat = (op == OP_MULH || op == OP_MULL) ? 9 : 0;
    @(negedge clk);
    alu_op = op; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = 8'h5A; B = 8'hC3; alu_op = OP_XOR;
    while (!done && n < 20) begin
      if (busy) busy_seen++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " busy_cycles"}, busy_seen, exp_lat);
    check({tag, " busy_with_done"}, busy, 0);
    check({tag, " result"}, result, exp_res);
    check({tag, " z"}, z, exp_z);
    check({tag, " err"}, err, exp_err);
    @(posedge clk); #1;
    check({tag, " done_pulse"}, done, 0);
    check({tag, " result_hold"}, result, exp_res);
  endtask

  initial begin
    int ndone;
    int done_at;

    #1 reset = 1'b1;
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst result", result, 0);
    check("rst z", z, 0);
    check("rst err", err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    run_op("add", OP_ADD, 8'h0A, 8'h05, 8'h0F, 1'b0, 1'b0);
    run_op("sub", OP_SUB, 8'h05, 8'h0A, 8'hFB, 1'b0, 1'b0);
    run_op("and", OP_AND, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0);
    run_op("or",  OP_OR,  8'hC0, 8'h0A, 8'hCA, 1'b0, 1'b0);
    run_op("xor", OP_XOR, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0);
    run_op("mulh_pos", OP_MULH, 8'h10, 8'h20, 8'h02, 1'b0, 1'b0);
    run_op("mull_zero", OP_MULL, 8'h10, 8'h20, 8'h00, 1'b1, 1'b0);
    run_op("mulh_neg", OP_MULH, 8'hF0, 8'h20, 8'hFE, 1'b0, 1'b0);
    run_op("mulh_min", OP_MULH, 8'h80, 8'h80, 8'h40, 1'b0, 1'b0);
    run_op("mull_m1", OP_MULL, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("mull_mix", OP_MULL, 8'h07, 8'hFD, 8'hEB, 1'b0, 1'b0);

    // Start while busy is ignored; then a back-to-back ADD in the done cycle.
    @(negedge clk);
    alu_op = OP_MULH; A = 8'h10; B = 8'h20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    alu_op = OP_ADD; A = 8'h01; B = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_start busy", busy, 1);
    check("busy_start done", done, 0);
    ndone = 0;
    done_at = 0;
    for (int i = 4; i <= 9; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        done_at = i;
      end
    end
    check("busy_start ndone", ndone, 1);
    check("busy_start done_at", done_at, 9);
    check("busy_start result", result, 8'h02);
    alu_op = OP_ADD; A = 8'h01; B = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b done", done, 1);
    check("b2b busy", busy, 0);
    check("b2b result", result, 8'h02);
    @(posedge clk); #1;
    check("b2b done_pulse", done, 0);

    // Reset in the middle of a multiply.
    run_op("pre_rst", OP_ADD, 8'h0A, 8'h05, 8'h0F, 1'b0, 1'b0);
    @(negedge clk);
    alu_op = OP_MULH; A = 8'h10; B = 8'h20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst result", result, 0);
    check("midrst z", z, 0);
    check("midrst err", err, 0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    check("midrst no_done", ndone, 0);
    run_op("post_rst", OP_ADD, 8'h0A, 8'h05, 8'h0F, 1'b0, 1'b0);

    // Reserved op sets err; the next valid op clears it.
    run_op("rsv", OP_RSV, 8'h0A, 8'h05, 8'h00, 1'b1, 1'b1);
    run_op("after_rsv", OP_ADD, 8'h0A, 8'h05, 8'h0F, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
